// File: rtl/debounce_multi_if.sv
// Button-side bundle for debounce_multi: raw inputs in, debounced levels and strobes out.
interface debounce_multi_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS-1:0] Boton;
  logic [CHANNELS-1:0] Out_Sinc;
  logic [CHANNELS-1:0] Press_Pulse;
  logic [CHANNELS-1:0] Release_Pulse;
  logic [CHANNELS-1:0] Repeat_Pulse;
  logic                Any_Level;

  modport master (
    output Boton,
    input  Out_Sinc, Press_Pulse, Release_Pulse, Repeat_Pulse, Any_Level
  );

  modport slave (
    input  Boton,
    output Out_Sinc, Press_Pulse, Release_Pulse, Repeat_Pulse, Any_Level
  );
endinterface

// File: rtl/debounce_multi.sv
// Multi-channel counter-based push-button debouncer with press/release strobes and
// typematic auto-repeat. Each channel is fully independent.
module debounce_multi #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 5000,
  parameter int unsigned REPEAT_CYCLES = 1000,
  parameter bit          REPEAT_EN     = 1'b1
) (
  input  logic             Clock,
  input  logic             Reset,
  debounce_multi_if.slave  bus
);

  localparam int unsigned StableW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned HoldW   = (HOLD_CYCLES > 1)   ? $clog2(HOLD_CYCLES)   : 1;
  localparam int unsigned RepW    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [StableW-1:0] StableMax = StableW'(STABLE_CYCLES - 1);
  localparam logic [HoldW-1:0]   HoldMax   = HoldW'(HOLD_CYCLES - 1);
  localparam logic [RepW-1:0]    RepMax    = RepW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;

  logic [CHANNELS-1:0] level_vec;
  logic [CHANNELS-1:0] press_vec;
  logic [CHANNELS-1:0] release_vec;
  logic [CHANNELS-1:0] repeat_vec;
  logic                any_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic               s1_q, s2_q;
    logic [StableW-1:0] stab_cnt_q, stab_cnt_d;
    logic               level_q, level_d;
    logic               rise, fall;
    logic               press_q, release_q;
    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [RepW-1:0]    rep_cnt_q, rep_cnt_d;
    logic               repeat_q, repeat_d;

    // Stability filter: the level only follows s2 after STABLE_CYCLES disagreeing samples.
    always_comb begin
      stab_cnt_d = stab_cnt_q;
      level_d    = level_q;
      if (s2_q == level_q) begin
        stab_cnt_d = '0;
      end else if (stab_cnt_q == StableMax) begin
        level_d    = s2_q;
        stab_cnt_d = '0;
      end else begin
        stab_cnt_d = stab_cnt_q + StableW'(1);
      end
      rise = level_d & ~level_q;
      fall = ~level_d & level_q;
    end

    // Repeat FSM; a falling level wins over any repeat due on the same edge.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      rep_cnt_d  = rep_cnt_q;
      repeat_d   = 1'b0;
      if (fall) begin
        state_d    = StIdle;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              state_d    = StHeld;
              hold_cnt_d = '0;
            end
          end
          StHeld: begin
            if (hold_cnt_q == HoldMax) begin
              // Without auto-repeat the hold counter simply saturates here.
              if (REPEAT_EN) begin
                repeat_d  = 1'b1;
                rep_cnt_d = '0;
                state_d   = StRepeat;
              end
            end else begin
              hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
          end
          StRepeat: begin
            if (rep_cnt_q == RepMax) begin
              repeat_d  = 1'b1;
              rep_cnt_d = '0;
            end else begin
              rep_cnt_d = rep_cnt_q + RepW'(1);
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        s1_q       <= 1'b0;
        s2_q       <= 1'b0;
        stab_cnt_q <= '0;
        level_q    <= 1'b0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        state_q    <= StIdle;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
        repeat_q   <= 1'b0;
      end else begin
        s1_q       <= bus.Boton[i];
        s2_q       <= s1_q;
        stab_cnt_q <= stab_cnt_d;
        level_q    <= level_d;
        press_q    <= rise;
        release_q  <= fall;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        rep_cnt_q  <= rep_cnt_d;
        repeat_q   <= repeat_d;
      end
    end

    assign level_vec[i]   = level_q;
    assign press_vec[i]   = press_q;
    assign release_vec[i] = release_q;
    assign repeat_vec[i]  = repeat_q;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |level_vec;
    end
  end

  assign bus.Out_Sinc      = level_vec;
  assign bus.Press_Pulse   = press_vec;
  assign bus.Release_Pulse = release_vec;
  assign bus.Repeat_Pulse  = repeat_vec;
  assign bus.Any_Level     = any_q;

endmodule
